// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM states, front-panel button bits
// and the rhythm entry layout.
package note_seq_pkg;

   typedef enum logic [2:0] {
      ST_GROUND        = 3'd0,
      ST_PITCH_ADJUST  = 3'd1,
      ST_PLAY_PITCH    = 3'd2,
      ST_RHYTHM_ADJUST = 3'd3,
      ST_PLAYBACK      = 3'd4
   } state_e;

   localparam int unsigned BTN_W    = 5;
   localparam int unsigned BTN_SEL  = 0;
   localparam int unsigned BTN_DN   = 1;
   localparam int unsigned BTN_UP   = 2;
   localparam int unsigned BTN_AUX  = 3;
   localparam int unsigned BTN_PLAY = 4;

   // Slot field is sized for up to 256 pitch slots.
   localparam int unsigned SLOT_W = 8;

   typedef struct packed {
      logic              rest;
      logic [SLOT_W-1:0] slot;
   } rhythm_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Front-panel inputs and audio-side outputs of the note sequencer.
interface note_sequencer_if
   import note_seq_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned NUM_STEPS = 8,
   parameter int unsigned NOTE_W    = 4
);
   localparam int unsigned STEP_W = $clog2(NUM_STEPS);

   logic [BTN_W-1:0]     btn;
   logic [NUM_SLOTS-1:0] sw;
   logic                 loop_mode;
   logic                 step_tick;
   logic [NOTE_W-1:0]    note_index;
   logic                 play;
   logic [2:0]           state;
   logic [STEP_W-1:0]    step;
   logic                 done;

   modport master (
      output btn, sw, loop_mode, step_tick,
      input  note_index, play, state, step, done
   );

   modport slave (
      input  btn, sw, loop_mode, step_tick,
      output note_index, play, state, step, done
   );
endinterface

// File: rtl/onehot_decode.sv
// Switch selector decode: index of the single set bit and a one-hot flag.
module onehot_decode #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]         sw_i,
   output logic [$clog2(N)-1:0] sel_c_o,
   output logic                 sel_valid_c_o
);
   localparam int unsigned SEL_W = $clog2(N);

   always_comb begin
      sel_c_o       = '0;
      sel_valid_c_o = (sw_i != '0) && ((sw_i & (sw_i - N'(1))) == '0);
      for (int unsigned i = 0; i < N; i++) begin
         if (sw_i[i]) sel_c_o = sel_c_o | SEL_W'(i);
      end
   end
endmodule

// File: rtl/note_sequencer.sv
// Pitch/rhythm editor and step sequencer driving the wave generator's
// note index and audio enable.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned NUM_STEPS = 8,
   parameter int unsigned NOTE_W    = 4,
   parameter int unsigned MAX_NOTE  = 12
) (
   input logic              clk,
   input logic              rst,
   note_sequencer_if.slave  bus
);
   localparam int unsigned SEL_W  = $clog2(NUM_SLOTS);
   localparam int unsigned STEP_W = $clog2(NUM_STEPS);
   localparam logic [NOTE_W-1:0] NOTE_MAX  = NOTE_W'(MAX_NOTE);
   localparam logic [SEL_W:0]    SEL_STEPS = (SEL_W+1)'(NUM_STEPS);

   logic [SEL_W-1:0] sel;
   logic             sel_valid;

   onehot_decode #(.N(NUM_SLOTS)) u_decode (
      .sw_i          (bus.sw),
      .sel_c_o       (sel),
      .sel_valid_c_o (sel_valid)
   );

   state_e            state_q;
   logic [NOTE_W-1:0] note_q;
   logic              play_q;
   logic              done_q;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] last_q;       // seq_len - 1
   logic [SEL_W-1:0]  edit_slot_q;
   logic [STEP_W-1:0] edit_step_q;
   logic [NOTE_W-1:0] pitch_q  [NUM_SLOTS];
   rhythm_t           rhythm_q [NUM_STEPS];

   logic              step_ok_c;
   logic [STEP_W-1:0] pb_step_c;
   rhythm_t           pb_entry_c;
   logic [NOTE_W-1:0] pb_note_c;
   rhythm_t           start_entry_c;
   logic [NOTE_W-1:0] start_note_c;

   function automatic logic [NOTE_W-1:0] slot_pitch(input logic [SLOT_W-1:0] s);
      logic [NOTE_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (s == SLOT_W'(i)) r = pitch_q[i];
      end
      return r;
   endfunction

   // Entry that will be current after this edge while playing.
   always_comb begin
      step_ok_c     = sel_valid && ({1'b0, sel} < SEL_STEPS);
      pb_step_c     = (step_q < last_q) ? step_q + STEP_W'(1) : '0;
      pb_entry_c    = rhythm_q[bus.step_tick ? pb_step_c : step_q];
      pb_note_c     = slot_pitch(pb_entry_c.slot);
      start_entry_c = rhythm_q[0];
      start_note_c  = slot_pitch(start_entry_c.slot);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_GROUND;
         note_q      <= '0;
         play_q      <= 1'b0;
         done_q      <= 1'b0;
         step_q      <= '0;
         last_q      <= STEP_W'(NUM_STEPS - 1);
         edit_slot_q <= '0;
         edit_step_q <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) pitch_q[i] <= '0;
         for (int unsigned i = 0; i < NUM_STEPS; i++) rhythm_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_GROUND: begin
               play_q <= 1'b0;
               if (bus.btn[BTN_SEL] && sel_valid) begin
                  edit_slot_q <= sel;
                  note_q      <= pitch_q[sel];
                  state_q     <= ST_PITCH_ADJUST;
               end else if (bus.btn[BTN_DN] && step_ok_c) begin
                  edit_step_q <= STEP_W'(sel);
                  state_q     <= ST_RHYTHM_ADJUST;
               end else if (bus.btn[BTN_AUX] && step_ok_c) begin
                  last_q <= STEP_W'(sel);
               end else if (bus.btn[BTN_PLAY]) begin
                  step_q  <= '0;
                  state_q <= ST_PLAYBACK;
                  play_q  <= !start_entry_c.rest;
                  if (!start_entry_c.rest) note_q <= start_note_c;
               end
            end
            ST_PITCH_ADJUST, ST_PLAY_PITCH: begin
               if (bus.btn[BTN_DN]) begin
                  if (note_q != '0) note_q <= note_q - NOTE_W'(1);
               end else if (bus.btn[BTN_UP]) begin
                  if (note_q < NOTE_MAX) note_q <= note_q + NOTE_W'(1);
               end else if (bus.btn[BTN_SEL]) begin
                  pitch_q[edit_slot_q] <= note_q;
                  state_q              <= ST_GROUND;
                  play_q               <= 1'b0;
               end else if (bus.btn[BTN_PLAY]) begin
                  state_q <= (state_q == ST_PITCH_ADJUST) ? ST_PLAY_PITCH : ST_PITCH_ADJUST;
                  play_q  <= (state_q == ST_PITCH_ADJUST);
               end
            end
            ST_RHYTHM_ADJUST: begin
               play_q <= 1'b0;
               if (bus.btn[BTN_DN] && sel_valid) begin
                  rhythm_q[edit_step_q] <= '{rest: 1'b0, slot: SLOT_W'(sel)};
                  state_q               <= ST_GROUND;
               end else if (bus.btn[BTN_AUX]) begin
                  rhythm_q[edit_step_q] <= '{rest: 1'b1, slot: '0};
                  state_q               <= ST_GROUND;
               end else if (bus.btn[BTN_SEL]) begin
                  state_q <= ST_GROUND;
               end
            end
            ST_PLAYBACK: begin
               if (bus.btn[BTN_PLAY]) begin
                  state_q <= ST_GROUND;
                  play_q  <= 1'b0;
               end else if (bus.step_tick && (step_q >= last_q) && !bus.loop_mode) begin
                  done_q  <= 1'b1;
                  step_q  <= '0;
                  state_q <= ST_GROUND;
                  play_q  <= 1'b0;
               end else begin
                  if (bus.step_tick) step_q <= pb_step_c;
                  play_q <= !pb_entry_c.rest;
                  if (!pb_entry_c.rest) note_q <= pb_note_c;
               end
            end
            default: begin
               state_q <= ST_GROUND;
               play_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state      = state_q;
   assign bus.note_index = note_q;
   assign bus.play       = play_q;
   assign bus.step       = step_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: edit, saturation, rhythm, playback,
// one-shot and asynchronous reset scenarios.
module tb_note_sequencer;
   import note_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   note_sequencer_if #(.NUM_SLOTS(8), .NUM_STEPS(8), .NOTE_W(4)) bus ();

   note_sequencer #(.NUM_SLOTS(8), .NUM_STEPS(8), .NOTE_W(4), .MAX_NOTE(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Drive one-cycle button pulse; returns at the negedge after the capturing edge.
   task automatic press(input int b);
      @(negedge clk);
      bus.btn = 5'(1 << b);
      @(negedge clk);
      bus.btn = '0;
   endtask

   task automatic press_n(input int b, input int n);
      for (int k = 0; k < n; k++) press(b);
   endtask

   task automatic tick();
      @(negedge clk);
      bus.step_tick = 1'b1;
      @(negedge clk);
      bus.step_tick = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
      n_checks++; if (bus.note_index !== 4'd0) begin n_fail++; $display("FAIL reset_note got %0d want 0", bus.note_index); end
      n_checks++; if (bus.play !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_play_done got %b%b want 00", bus.play, bus.done); end
      n_checks++; if (bus.step !== 3'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", bus.step); end
   endtask

   task automatic test_pitch_edit();
      bus.sw = 8'b0000_0100;
      press(BTN_SEL);
      n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL edit_enter_state got %0d want 1", bus.state); end
      n_checks++; if (bus.note_index !== 4'd0) begin n_fail++; $display("FAIL edit_enter_note got %0d want 0", bus.note_index); end
      press_n(BTN_UP, 3);
      n_checks++; if (bus.note_index !== 4'd3) begin n_fail++; $display("FAIL edit_up3 got %0d want 3", bus.note_index); end
      press(BTN_SEL);
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL edit_commit_state got %0d want 0", bus.state); end
      // Re-enter slot 2 to see the committed value, then cancel-free exit.
      press(BTN_SEL);
      n_checks++; if (bus.note_index !== 4'd3) begin n_fail++; $display("FAIL edit_reload got %0d want 3", bus.note_index); end
      press(BTN_SEL);
   endtask

   task automatic test_saturation();
      bus.sw = 8'b0010_0000;
      press(BTN_SEL);
      press_n(BTN_UP, 15);
      n_checks++; if (bus.note_index !== 4'd12) begin n_fail++; $display("FAIL sat_high got %0d want 12", bus.note_index); end
      press_n(BTN_DN, 15);
      n_checks++; if (bus.note_index !== 4'd0) begin n_fail++; $display("FAIL sat_low got %0d want 0", bus.note_index); end
      press(BTN_PLAY);
      n_checks++; if (bus.state !== 3'd2 || bus.play !== 1'b1) begin n_fail++; $display("FAIL play_pitch got state %0d play %b want 2 1", bus.state, bus.play); end
      press(BTN_PLAY);
      n_checks++; if (bus.state !== 3'd1 || bus.play !== 1'b0) begin n_fail++; $display("FAIL pitch_back got state %0d play %b want 1 0", bus.state, bus.play); end
      press(BTN_SEL);
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL sat_exit got %0d want 0", bus.state); end
   endtask

   task automatic test_invalid_sel();
      bus.sw = 8'b0000_0110;
      press(BTN_SEL);
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL twohot_sel got %0d want 0", bus.state); end
      bus.sw = 8'b0000_0000;
      press(BTN_DN);
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL zero_sel got %0d want 0", bus.state); end
   endtask

   task automatic test_loop_playback();
      bus.sw = 8'b0000_0001;
      press(BTN_DN);
      n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL rhythm_enter got %0d want 3", bus.state); end
      bus.sw = 8'b0000_0100;
      press(BTN_DN);
      bus.sw = 8'b0000_0010;
      press(BTN_DN);
      press(BTN_AUX);
      n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rhythm_rest_exit got %0d want 0", bus.state); end
      press(BTN_AUX);
      bus.loop_mode = 1'b1;
      press(BTN_PLAY);
      n_checks++; if (bus.state !== 3'd4 || bus.step !== 3'd0) begin n_fail++; $display("FAIL pb_start got state %0d step %0d want 4 0", bus.state, bus.step); end
      n_checks++; if (bus.note_index !== 4'd3 || bus.play !== 1'b1) begin n_fail++; $display("FAIL pb_step0 got note %0d play %b want 3 1", bus.note_index, bus.play); end
      tick();
      n_checks++; if (bus.step !== 3'd1 || bus.play !== 1'b0 || bus.note_index !== 4'd3) begin n_fail++; $display("FAIL pb_step1 got step %0d play %b note %0d want 1 0 3", bus.step, bus.play, bus.note_index); end
      tick();
      n_checks++; if (bus.step !== 3'd0 || bus.play !== 1'b1) begin n_fail++; $display("FAIL pb_wrap got step %0d play %b want 0 1", bus.step, bus.play); end
      tick();
      n_checks++; if (bus.step !== 3'd1 || bus.play !== 1'b0) begin n_fail++; $display("FAIL pb_step1b got step %0d play %b want 1 0", bus.step, bus.play); end
      press(BTN_PLAY);
      n_checks++; if (bus.state !== 3'd0 || bus.play !== 1'b0) begin n_fail++; $display("FAIL pb_stop got state %0d play %b want 0 0", bus.state, bus.play); end
   endtask

   task automatic test_slot_reference();
      bus.sw = 8'b0000_0100;
      press(BTN_SEL);
      press_n(BTN_UP, 4);
      press(BTN_SEL);
      press(BTN_PLAY);
      n_checks++; if (bus.note_index !== 4'd7 || bus.play !== 1'b1) begin n_fail++; $display("FAIL ref_note got note %0d play %b want 7 1", bus.note_index, bus.play); end
      press(BTN_PLAY);
   endtask

   task automatic test_one_shot();
      bus.sw = 8'b0000_0100;
      press(BTN_AUX);
      bus.loop_mode = 1'b0;
      press(BTN_PLAY);
      tick();
      tick();
      n_checks++; if (bus.step !== 3'd2 || bus.note_index !== 4'd0 || bus.play !== 1'b1) begin n_fail++; $display("FAIL os_step2 got step %0d note %0d play %b want 2 0 1", bus.step, bus.note_index, bus.play); end
      tick();
      n_checks++; if (bus.done !== 1'b1 || bus.state !== 3'd0 || bus.step !== 3'd0) begin n_fail++; $display("FAIL os_done got done %b state %0d step %0d want 1 0 0", bus.done, bus.state, bus.step); end
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL os_done_pulse got %b want 0", bus.done); end
   endtask

   task automatic test_stop_vs_tick();
      press(BTN_PLAY);
      @(negedge clk);
      bus.btn       = 5'b1_0000;
      bus.step_tick = 1'b1;
      @(negedge clk);
      bus.btn       = '0;
      bus.step_tick = 1'b0;
      n_checks++; if (bus.state !== 3'd0 || bus.step !== 3'd0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL stop_tick got state %0d step %0d done %b want 0 0 0", bus.state, bus.step, bus.done); end
   endtask

   task automatic test_async_reset();
      bus.loop_mode = 1'b1;
      press(BTN_PLAY);
      tick();
      n_checks++; if (bus.step !== 3'd1 || bus.note_index !== 4'd7) begin n_fail++; $display("FAIL pre_rst got step %0d note %0d want 1 7", bus.step, bus.note_index); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (bus.state !== 3'd0 || bus.step !== 3'd0 || bus.note_index !== 4'd0 || bus.play !== 1'b0) begin n_fail++; $display("FAIL async_rst got state %0d step %0d note %0d play %b want 0 0 0 0", bus.state, bus.step, bus.note_index, bus.play); end
      @(negedge clk);
      rst = 1'b0;
      bus.sw = 8'b0000_0100;
      press(BTN_SEL);
      n_checks++; if (bus.state !== 3'd1 || bus.note_index !== 4'd0) begin n_fail++; $display("FAIL pitch_cleared got state %0d note %0d want 1 0", bus.state, bus.note_index); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.btn       = '0;
      bus.sw        = '0;
      bus.loop_mode = 1'b0;
      bus.step_tick = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_pitch_edit();
      test_saturation();
      test_invalid_sel();
      test_loop_playback();
      test_slot_reference();
      test_one_shot();
      test_stop_vs_tick();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised successor to the lab-4 pitch/rhythm controller. Holds a bank of editable pitch slots and a rhythm pattern of steps that reference those slots or rests. Exposes the same edit/audition/playback front panel, with programmable sequence length and loop or one-shot playback. Sits between the button debouncer/switch inputs and `wave_generator`/`pmod_i2s_controller`, driving `note_index` and `play`.

## Interface
Parameters:
- `NUM_SLOTS`, 8: pitch slots; also the width of `sw`.
- `NUM_STEPS`, 8: rhythm steps. Must satisfy 2 ≤ `NUM_STEPS` ≤ `NUM_SLOTS`.
- `NOTE_W`, 4: note index width.
- `MAX_NOTE`, 12: highest legal note index. Must be < 2^`NOTE_W`.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in 5: single-cycle pulses from the upstream debouncer.
  - [0] select/exit, [1] down/rhythm, [2] up, [3] aux, [4] play/stop.
- `sw` in `NUM_SLOTS`: selector; valid only when exactly one bit is set.
- `loop_mode` in 1: 1 = loop playback, 0 = one-shot.
- `step_tick` in 1: one-cycle strobe per rhythm step, in the `clk` domain.
- `note_index` out `NOTE_W`: note fed to the wave generator.
- `play` out 1: audio enable.
- `state` out 3: current state, routed to the LEDs.
- `step` out clog2(`NUM_STEPS`): current playback step.
- `done` out 1: one-cycle pulse when a one-shot pass ends.

## Operation
- `sel` = index of the single set bit of `sw`; `sel_valid` = `sw` is one-hot.
- States: GROUND=0, PITCH_ADJUST=1, PLAY_PITCH=2, RHYTHM_ADJUST=3, PLAYBACK=4. Illegal encodings go to GROUND.

GROUND (priority btn0 > btn1 > btn3 > btn4):
- btn0 & `sel_valid`: load `edit_slot`=`sel`, load `note_index`=pitch[`sel`], go to PITCH_ADJUST.
- btn1 & `sel_valid` & `sel`<`NUM_STEPS`: load `edit_step`=`sel`, go to RHYTHM_ADJUST.
- btn3 & `sel_valid` & `sel`<`NUM_STEPS`: `seq_len`=`sel`+1.
- btn4: `step`=0, go to PLAYBACK.

PITCH_ADJUST / PLAY_PITCH (priority btn1 > btn2 > btn0 > btn4):
- btn1: decrement `note_index`, saturating at 0.
- btn2: increment `note_index`, saturating at `MAX_NOTE`.
- btn0: commit `note_index` to pitch[`edit_slot`] and go to GROUND. Commit happens in both states.
- btn4: toggle between PITCH_ADJUST and PLAY_PITCH.

RHYTHM_ADJUST (priority btn1 > btn3 > btn0):
- btn1 & `sel_valid`: rhythm[`edit_step`] = {rest=0, slot=`sel`}, go to GROUND.
- btn3: rhythm[`edit_step`] = {rest=1}, go to GROUND.
- btn0: cancel, go to GROUND.

Rhythm references:
- Rhythm stores slot references, not pitch values. Later pitch edits are therefore heard on playback.

PLAYBACK:
- `note_index` = pitch[rhythm[`step`].slot], or held at its previous value on a rest.
- On `step_tick`:
  - If `step`<`seq_len`−1, `step`++.
  - Otherwise, if `loop_mode`, `step`=0.
  - Otherwise, pulse `done`, set `step`=0 and go to GROUND.
- btn4 stops playback and goes to GROUND. btn4 wins over a simultaneous `step_tick`.

Outputs:
- `play` = (PLAY_PITCH) | (PLAYBACK & current step not a rest).
- Buttons in states with no action listed are ignored.

## Timing
- All outputs are registered and reflect the state/data after the edge on which the input was sampled (latency 1 cycle).
- Reset values:
  - `state`=GROUND, `note_index`=0, `play`=0, `step`=0, `done`=0.
  - `seq_len`=`NUM_STEPS`.
  - All pitches 0.
  - All rhythm entries {rest=0, slot=0}.
- Reset mid-playback or mid-edit discards uncommitted `note_index` edits immediately (asynchronous reset).
- `seq_len` changes take effect at the next wrap check; a `step` ≥ new `seq_len` wraps on the next tick.
- `loop_mode` is sampled at the tick on the last step only.

## Structure
- Package `note_seq_pkg`: state enum/localparams, button bit indices (`BTN_SEL`=0, `BTN_DN`=1, `BTN_UP`=2, `BTN_AUX`=3, `BTN_PLAY`=4), and the rhythm entry type {rest, slot}.
- Sub-module `onehot_decode` (parametrised `N`): `sw` → `sel`, `sel_valid`.
- Pitch and rhythm banks are flop arrays. No RAM inference, because of async reset.

## Test plan
- Reset, then set `sw`=8'b0000_0100 and pulse btn0: state=1, `note_index`=0. Three btn2, then btn0: pitch[2]=3, state=0.
- In PITCH_ADJUST, 15× btn2: `note_index` saturates at 12. 15× btn1: saturates at 0. btn4: state=2, `play`=1.
- Map rhythm[0]→slot2 and rhythm[1]→rest. Set `seq_len`=2, `loop_mode`=1, pulse btn4. Ticks give `note_index` 3, `play` 1,0,1,0… and `step` 0,1,0,1.
- Edit pitch[2] to 7 while the pattern above is assigned, then play: step 0 outputs 7.
- `loop_mode`=0, `seq_len`=3: after the 3rd tick, `done`=1 for one cycle, state=0, `step`=0. btn4 and `step_tick` in the same cycle: state=0, no step advance.
- Assert `rst` mid-PLAYBACK: all outputs return to reset values within the same cycle, and the pitch bank is cleared.
